// File: rtl/cpu_pkg.sv
// Shared back-end definitions: ROB sizing and the ROB entry layout.
// Dispatch, issue and LSU size their ROB indices from ROB_LEN.
package cpu_pkg;

    localparam int ROB_LEN = 16;

    typedef struct packed {
        logic        valid;
        logic        done;
        logic        mispred;
        logic [31:0] target;
        logic [31:0] pc;
        logic [5:0]  rd_arch;
        logic [6:0]  P_rd_new;
        logic [6:0]  P_rd_old;
        logic        has_rd;
        logic        is_store;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: dispatch at tail, complete anywhere, retire at head.
// Optional perf counters under `define ROB_PERF_CNT_EN.
module reorder_buffer #(
    parameter  int ROB_LEN = cpu_pkg::ROB_LEN,
    localparam int IDX_W   = $clog2(ROB_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dispatch_valid,
    input  logic [31:0]      dispatch_pc,
    input  logic [5:0]       dispatch_rd_arch,
    input  logic [6:0]       dispatch_P_rd_new,
    input  logic [6:0]       dispatch_P_rd_old,
    input  logic             dispatch_has_rd,
    input  logic             dispatch_is_store,
    output logic             rob_ready,
    output logic             rob_empty,
    output logic [IDX_W-1:0] rob_idx,
    input  logic             wb_valid,
    input  logic [IDX_W-1:0] wb_rob_idx,
    input  logic             wb_mispredict,
    input  logic [31:0]      wb_target,
    output logic             commit_valid,
    output logic [31:0]      commit_pc,
    output logic [5:0]       commit_rd_arch,
    output logic [6:0]       commit_P_rd_new,
    output logic [6:0]       commit_P_rd_old,
    output logic             commit_has_rd,
    output logic             commit_is_store,
    output logic             mispredict,
`ifdef ROB_PERF_CNT_EN
    output logic [31:0]      perf_commit_cnt,
    output logic [31:0]      perf_flush_cnt,
`endif
    output logic [31:0]      redirect_pc
);
    import cpu_pkg::*;

    rob_entry_t       r_rob [ROB_LEN];
    logic [IDX_W:0]   r_head;
    logic [IDX_W:0]   r_tail;
    logic             r_mispredict;
    logic [31:0]      r_redirect_pc;

    logic [IDX_W-1:0] w_hidx;
    logic [IDX_W-1:0] w_tidx;
    logic             w_full;
    logic             w_disp;
    logic             w_wb;
    logic             w_flush;
    rob_entry_t       w_head;

    assign w_hidx = r_head[IDX_W-1:0];
    assign w_tidx = r_tail[IDX_W-1:0];
    assign w_head = r_rob[w_hidx];

    // Wrap bit distinguishes full from empty when the indices match.
    assign w_full = (w_hidx == w_tidx) && (r_head[IDX_W] != r_tail[IDX_W]);

    assign rob_ready = !w_full;
    assign rob_empty = (r_head == r_tail);
    assign rob_idx   = w_tidx;

    assign commit_valid    = w_head.valid && w_head.done && !r_mispredict;
    assign commit_pc       = w_head.pc;
    assign commit_rd_arch  = w_head.rd_arch;
    assign commit_P_rd_new = w_head.P_rd_new;
    assign commit_P_rd_old = w_head.P_rd_old;
    assign commit_has_rd   = w_head.has_rd;
    assign commit_is_store = w_head.is_store;

    assign w_disp  = dispatch_valid && !w_full && !r_mispredict;
    assign w_wb    = wb_valid && !r_mispredict && r_rob[wb_rob_idx].valid;
    assign w_flush = commit_valid && w_head.mispred;

    assign mispredict  = r_mispredict;
    assign redirect_pc = r_redirect_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_mispredict  <= 1'b0;
            r_redirect_pc <= '0;
            for (int i = 0; i < ROB_LEN; i++) begin
                r_rob[i] <= '0;
            end
        end else begin
            r_mispredict <= w_flush;
            if (w_flush) begin
                r_redirect_pc <= w_head.target;
                r_head        <= '0;
                r_tail        <= '0;
                for (int i = 0; i < ROB_LEN; i++) begin
                    r_rob[i].valid <= 1'b0;
                    r_rob[i].done  <= 1'b0;
                end
            end else begin
                if (w_wb) begin
                    r_rob[wb_rob_idx].done    <= 1'b1;
                    r_rob[wb_rob_idx].mispred <= wb_mispredict;
                    r_rob[wb_rob_idx].target  <= wb_target;
                end
                if (commit_valid) begin
                    r_rob[w_hidx].valid <= 1'b0;
                    r_rob[w_hidx].done  <= 1'b0;
                    r_head              <= r_head + (IDX_W+1)'(1);
                end
                if (w_disp) begin
                    r_rob[w_tidx] <= '{
                        valid:    1'b1,
                        done:     1'b0,
                        mispred:  1'b0,
                        target:   32'h0,
                        pc:       dispatch_pc,
                        rd_arch:  dispatch_rd_arch,
                        P_rd_new: dispatch_P_rd_new,
                        P_rd_old: dispatch_P_rd_old,
                        has_rd:   dispatch_has_rd,
                        is_store: dispatch_is_store
                    };
                    r_tail <= r_tail + (IDX_W+1)'(1);
                end
            end
        end
    end

`ifdef ROB_PERF_CNT_EN
    logic [31:0] r_perf_commit_cnt;
    logic [31:0] r_perf_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_commit_cnt <= '0;
            r_perf_flush_cnt  <= '0;
        end else begin
            if (commit_valid) r_perf_commit_cnt <= r_perf_commit_cnt + 32'd1;
            if (r_mispredict) r_perf_flush_cnt  <= r_perf_flush_cnt + 32'd1;
        end
    end

    assign perf_commit_cnt = r_perf_commit_cnt;
    assign perf_flush_cnt  = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed vector bench for reorder_buffer (default ROB_LEN = 16).
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        dispatch_valid;
    logic [31:0] dispatch_pc;
    logic [5:0]  dispatch_rd_arch;
    logic [6:0]  dispatch_P_rd_new;
    logic [6:0]  dispatch_P_rd_old;
    logic        dispatch_has_rd;
    logic        dispatch_is_store;
    logic        rob_ready;
    logic        rob_empty;
    logic [3:0]  rob_idx;
    logic        wb_valid;
    logic [3:0]  wb_rob_idx;
    logic        wb_mispredict;
    logic [31:0] wb_target;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [5:0]  commit_rd_arch;
    logic [6:0]  commit_P_rd_new;
    logic [6:0]  commit_P_rd_old;
    logic        commit_has_rd;
    logic        commit_is_store;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_commit_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk               (clk),
        .rst               (rst),
        .dispatch_valid    (dispatch_valid),
        .dispatch_pc       (dispatch_pc),
        .dispatch_rd_arch  (dispatch_rd_arch),
        .dispatch_P_rd_new (dispatch_P_rd_new),
        .dispatch_P_rd_old (dispatch_P_rd_old),
        .dispatch_has_rd   (dispatch_has_rd),
        .dispatch_is_store (dispatch_is_store),
        .rob_ready         (rob_ready),
        .rob_empty         (rob_empty),
        .rob_idx           (rob_idx),
        .wb_valid          (wb_valid),
        .wb_rob_idx        (wb_rob_idx),
        .wb_mispredict     (wb_mispredict),
        .wb_target         (wb_target),
        .commit_valid      (commit_valid),
        .commit_pc         (commit_pc),
        .commit_rd_arch    (commit_rd_arch),
        .commit_P_rd_new   (commit_P_rd_new),
        .commit_P_rd_old   (commit_P_rd_old),
        .commit_has_rd     (commit_has_rd),
        .commit_is_store   (commit_is_store),
        .mispredict        (mispredict),
`ifdef ROB_PERF_CNT_EN
        .perf_commit_cnt   (perf_commit_cnt),
        .perf_flush_cnt    (perf_flush_cnt),
`endif
        .redirect_pc       (redirect_pc)
    );

    typedef struct {
        logic        rs;
        logic        dv;
        logic [31:0] pc;
        logic [6:0]  po;
        logic        wv;
        logic [3:0]  wi;
        logic        wm;
        logic [31:0] wt;
        logic        e_ready;
        logic        e_empty;
        logic [3:0]  e_idx;
        logic        e_cv;
        logic [31:0] e_pc;
        logic [6:0]  e_po;
        logic        e_mis;
        logic [31:0] e_redir;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic rs, input logic dv, input logic [31:0] pc,
        input logic [6:0] po, input logic wv, input logic [3:0] wi,
        input logic wm, input logic [31:0] wt,
        input logic er, input logic ee, input logic [3:0] ei,
        input logic ecv, input logic [31:0] epc, input logic [6:0] epo,
        input logic em, input logic [31:0] ered);
        vec_t v;
        v = '{rs, dv, pc, po, wv, wi, wm, wt,
              er, ee, ei, ecv, epc, epo, em, ered};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic dv,
                         input logic [31:0] pc, input logic [6:0] po,
                         input logic wv, input logic [3:0] wi,
                         input logic wm, input logic [31:0] wt);
        rst               = rs;
        dispatch_valid    = dv;
        dispatch_pc       = pc;
        dispatch_rd_arch  = pc[7:2];
        dispatch_P_rd_new = po ^ 7'h40;
        dispatch_P_rd_old = po;
        dispatch_has_rd   = 1'b1;
        dispatch_is_store = pc[2];
        wb_valid          = wv;
        wb_rob_idx        = wi;
        wb_mispredict     = wm;
        wb_target         = wt;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 7'h0, 1'b0, 4'h0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 7'h0, 1'b0, 4'h0, 1'b0, 32'h0);
        @(negedge clk);
        idle();
    endtask

    logic [31:0] q_pc[$];
    logic [31:0] exp_pc;
    int          n_commit;
    int          c;

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // rs dv pc po wv wi wm wt | ready empty idx cv pc po mis redir
        vt.push_back(mk(0,0,32'h000,7'd0, 0,0,0,32'h0,    1,1,0,0,32'h000,7'd0, 0,32'h0));
        vt.push_back(mk(0,1,32'h100,7'd10,0,0,0,32'h0,    1,1,0,0,32'h000,7'd0, 0,32'h0));
        vt.push_back(mk(0,1,32'h104,7'd11,0,0,0,32'h0,    1,0,1,0,32'h000,7'd0, 0,32'h0));
        vt.push_back(mk(0,1,32'h108,7'd12,0,0,0,32'h0,    1,0,2,0,32'h000,7'd0, 0,32'h0));
        vt.push_back(mk(0,1,32'h10C,7'd13,0,0,0,32'h0,    1,0,3,0,32'h000,7'd0, 0,32'h0));
        vt.push_back(mk(0,0,32'h000,7'd0, 1,2,0,32'h0,    1,0,4,0,32'h000,7'd0, 0,32'h0));
        vt.push_back(mk(0,0,32'h000,7'd0, 1,0,0,32'h0,    1,0,4,0,32'h000,7'd0, 0,32'h0));
        vt.push_back(mk(0,0,32'h000,7'd0, 1,3,0,32'h0,    1,0,4,1,32'h100,7'd10,0,32'h0));
        vt.push_back(mk(0,0,32'h000,7'd0, 1,1,0,32'h0,    1,0,4,0,32'h000,7'd0, 0,32'h0));
        vt.push_back(mk(0,0,32'h000,7'd0, 0,0,0,32'h0,    1,0,4,1,32'h104,7'd11,0,32'h0));
        vt.push_back(mk(0,0,32'h000,7'd0, 0,0,0,32'h0,    1,0,4,1,32'h108,7'd12,0,32'h0));
        vt.push_back(mk(0,0,32'h000,7'd0, 0,0,0,32'h0,    1,0,4,1,32'h10C,7'd13,0,32'h0));
        vt.push_back(mk(0,0,32'h000,7'd0, 0,0,0,32'h0,    1,1,4,0,32'h000,7'd0, 0,32'h0));
        vt.push_back(mk(1,0,32'h000,7'd0, 0,0,0,32'h0,    1,1,4,0,32'h000,7'd0, 0,32'h0));
        vt.push_back(mk(0,1,32'h200,7'd20,0,0,0,32'h0,    1,1,0,0,32'h000,7'd0, 0,32'h0));
        vt.push_back(mk(0,1,32'h204,7'd21,0,0,0,32'h0,    1,0,1,0,32'h000,7'd0, 0,32'h0));
        vt.push_back(mk(0,1,32'h208,7'd22,0,0,0,32'h0,    1,0,2,0,32'h000,7'd0, 0,32'h0));
        vt.push_back(mk(0,1,32'h20C,7'd23,0,0,0,32'h0,    1,0,3,0,32'h000,7'd0, 0,32'h0));
        vt.push_back(mk(0,1,32'h210,7'd24,0,0,0,32'h0,    1,0,4,0,32'h000,7'd0, 0,32'h0));
        vt.push_back(mk(0,0,32'h000,7'd0, 1,1,1,32'h2000, 1,0,5,0,32'h000,7'd0, 0,32'h0));
        vt.push_back(mk(0,0,32'h000,7'd0, 1,0,0,32'h0,    1,0,5,0,32'h000,7'd0, 0,32'h0));
        vt.push_back(mk(0,0,32'h000,7'd0, 0,0,0,32'h0,    1,0,5,1,32'h200,7'd20,0,32'h0));
        vt.push_back(mk(0,0,32'h000,7'd0, 1,2,0,32'h0,    1,0,5,1,32'h204,7'd21,0,32'h0));
        vt.push_back(mk(0,1,32'h300,7'd30,1,3,0,32'h0,    1,1,0,0,32'h000,7'd0, 1,32'h2000));
        vt.push_back(mk(0,0,32'h000,7'd0, 0,0,0,32'h0,    1,1,0,0,32'h000,7'd0, 0,32'h0));
        vt.push_back(mk(0,1,32'h300,7'd30,0,0,0,32'h0,    1,1,0,0,32'h000,7'd0, 0,32'h0));
        vt.push_back(mk(0,0,32'h000,7'd0, 0,0,0,32'h0,    1,0,1,0,32'h000,7'd0, 0,32'h0));

        @(negedge clk);
        idle();
        #1;
        chk("reset_redirect_pc", redirect_pc, 32'h0);

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            drive(vt[i].rs, vt[i].dv, vt[i].pc, vt[i].po,
                  vt[i].wv, vt[i].wi, vt[i].wm, vt[i].wt);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(rob_ready), 32'(vt[i].e_ready));
            chk($sformatf("v%0d_empty", i), 32'(rob_empty), 32'(vt[i].e_empty));
            chk($sformatf("v%0d_idx", i), 32'(rob_idx), 32'(vt[i].e_idx));
            chk($sformatf("v%0d_cv", i), 32'(commit_valid), 32'(vt[i].e_cv));
            chk($sformatf("v%0d_mis", i), 32'(mispredict), 32'(vt[i].e_mis));
            if (vt[i].e_cv) begin
                chk($sformatf("v%0d_cpc", i), commit_pc, vt[i].e_pc);
                chk($sformatf("v%0d_pold", i), 32'(commit_P_rd_old), 32'(vt[i].e_po));
            end
            if (vt[i].e_mis)
                chk($sformatf("v%0d_redir", i), redirect_pc, vt[i].e_redir);
        end

        // Fill to 16, then press against full with and without a commit.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 32'h400 + 32'(4*i), 7'(i), 1'b0, 4'h0, 1'b0, 32'h0);
            #1;
            chk("fill_idx", 32'(rob_idx), 32'(i));
            chk("fill_ready", 32'(rob_ready), 32'd1);
            @(negedge clk);
        end
        drive(1'b0, 1'b1, 32'hBAD, 7'h7F, 1'b0, 4'h0, 1'b0, 32'h0);
        #1;
        chk("full_ready", 32'(rob_ready), 32'd0);
        chk("full_idx", 32'(rob_idx), 32'd0);
        chk("full_empty", 32'(rob_empty), 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b1, 32'hBAD, 7'h7F, 1'b1, 4'h0, 1'b0, 32'h0);
        #1;
        chk("ovf_ignored_ready", 32'(rob_ready), 32'd0);
        chk("ovf_ignored_idx", 32'(rob_idx), 32'd0);
        chk("ovf_cv", 32'(commit_valid), 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b1, 32'hBAD, 7'h7F, 1'b0, 4'h0, 1'b0, 32'h0);
        #1;
        chk("full_commit_cv", 32'(commit_valid), 32'd1);
        chk("full_commit_pc", commit_pc, 32'h400);
        chk("full_commit_ready", 32'(rob_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("after_commit_ready", 32'(rob_ready), 32'd1);
        chk("after_commit_idx", 32'(rob_idx), 32'd0);
        chk("after_commit_cv", 32'(commit_valid), 32'd0);
        @(negedge clk);
        idle();
        #1;
        chk("refill_ready", 32'(rob_ready), 32'd0);
        chk("refill_idx", 32'(rob_idx), 32'd1);
        chk("refill_head_pc", commit_pc, 32'h404);

        // Stream 40 with completion one cycle after dispatch.
        do_reset();
        n_commit = 0;
        for (c = 0; c < 60; c++) begin
            drive(1'b0, c < 40, 32'h1000 + 32'(4*c), 7'(c),
                  (c >= 1) && (c <= 40), 4'((c - 1) % 16), 1'b0, 32'h0);
            #1;
            if (c < 40) chk("stream_idx", 32'(rob_idx), 32'(c % 16));
            if (commit_valid) begin
                if (q_pc.size() == 0) begin
                    chk("stream_extra_commit", commit_pc, 32'hFFFF_FFFF);
                end else begin
                    exp_pc = q_pc.pop_front();
                    chk("stream_pc", commit_pc, exp_pc);
                    chk("stream_pold", 32'(commit_P_rd_old),
                        32'(7'((exp_pc - 32'h1000) >> 2)));
                    chk("stream_store", 32'(commit_is_store), 32'(exp_pc[2]));
                end
                n_commit++;
            end
            if (c < 40) q_pc.push_back(32'h1000 + 32'(4*c));
            @(negedge clk);
            if (n_commit == 40 && c > 41) break;
        end
        idle();
        #1;
        chk("stream_commit_count", 32'(n_commit), 32'd40);
        chk("stream_empty", 32'(rob_empty), 32'd1);
        chk("stream_idx_end", 32'(rob_idx), 32'(40 % 16));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order buffer at the back end of the out-of-order core.
- Accepts one dispatch per cycle from the decode/dispatch stage and returns the allocated ROB index plus ready/empty status.
- Records out-of-order completions from the writeback/CDB side.
- Retires at most one instruction per cycle in program order.
  - Retiring releases the old physical register to the free list and releases stores to the store queue.
  - Retiring a mispredicted branch flushes the whole ROB and raises a one-cycle redirect.

Parameters:
- ROB_LEN, 16, number of entries; must be a power of two ≥ 4.
- IDX_W, $clog2(ROB_LEN), width of an entry index; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- dispatch_valid  in  1  dispatch request this cycle
- dispatch_pc  in  32  instruction PC
- dispatch_rd_arch  in  6  architectural rd; bit5 = FP file
- dispatch_P_rd_new  in  7  newly allocated physical rd
- dispatch_P_rd_old  in  7  previous mapping of rd
- dispatch_has_rd  in  1  instruction writes rd
- dispatch_is_store  in  1  instruction is a store (S_TYPE or FSTORE)
- rob_ready  out  1  an entry is free
- rob_empty  out  1  no valid entries
- rob_idx  out  IDX_W  index the next dispatch will receive
- wb_valid  in  1  completion report
- wb_rob_idx  in  IDX_W  completing entry
- wb_mispredict  in  1  completing branch/jump was mispredicted
- wb_target  in  32  correct next PC when wb_mispredict=1
- commit_valid  out  1  head entry retires this cycle
- commit_pc  out  32  PC of the retiring entry
- commit_rd_arch  out  6  architectural rd of the retiring entry
- commit_P_rd_new  out  7  physical rd made architectural
- commit_P_rd_old  out  7  physical rd to free
- commit_has_rd  out  1  qualifies rd and P_rd fields
- commit_is_store  out  1  store may drain from the store queue
- mispredict  out  1  flush pulse to the front end, rename and LSU
- redirect_pc  out  32  fetch target, valid while mispredict=1

Behaviour:
- State:
  - head and tail pointers, each IDX_W+1 bits (the extra bit is the wrap bit).
  - Per-entry fields: valid, done, mispred, target, pc, rd_arch, P_rd_new, P_rd_old, has_rd, is_store.
- Reset: head=tail=0; all valid/done=0; mispredict=0; redirect_pc=0; commit_valid=0; rob_empty=1; rob_ready=1; rob_idx=0.
- Occupancy:
  - full when the index bits of head and tail are equal and the wrap bits differ.
  - empty when head == tail.
  - rob_ready = !full; rob_empty = empty; rob_idx = tail[IDX_W-1:0]. All combinational.
- Dispatch:
  - Accepted when dispatch_valid && rob_ready && !mispredict.
  - On accept, the entry at tail is written with valid=1, done=0, mispred=0, and tail increments (the index wraps, the wrap bit toggles).
  - dispatch_valid while full is ignored.
  - Full is evaluated before the same-cycle commit, so a full ROB accepts nothing even when it retires that cycle.
- Completion:
  - On wb_valid, if entry[wb_rob_idx].valid, set done=1, mispred=wb_mispredict, target=wb_target. Otherwise ignore.
  - A completion on the same edge as a commit of that entry cannot occur, because commit requires done=1 already.
- Commit (combinational from the head entry):
  - commit_valid = entry[head].valid && entry[head].done && !mispredict.
  - The commit_* fields mirror entry[head].
  - When commit_valid=1, the entry is cleared and head increments at the edge.
- Flush:
  - If the committing entry has mispred=1, then at the same edge all valid/done are cleared, head=tail=0, mispredict<=1 and redirect_pc<=target.
  - mispredict is high for exactly one cycle.
  - In that cycle: no commit, no dispatch accepted, wb_valid ignored.
- Simultaneous dispatch + commit in one cycle: both take effect; count is unchanged.
- Latency:
  - dispatch → earliest commit: entry written at edge N; commit possible in cycle N+1 once done.
  - wb → commit: next cycle.
- rst mid-operation overrides flush, dispatch and commit.

Optional Feature:
- Macro ROB_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_commit_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_commit_cnt increments on each commit_valid (mispredicted branches included).
  - perf_flush_cnt increments on each mispredict pulse.
  - Both are zero on rst and wrap at 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg:
  - rob_entry_t packed struct with fields valid, done, mispred, target, pc, rd_arch, P_rd_new, P_rd_old, has_rd, is_store.
  - ROB_LEN default, so dispatch, issue and LSU all size rob indices from it.
- No sub-module. Pointer logic and the entry array live in one module; the perf counters are an inline `ifdef block.

Test Plan:
- Reset → rob_empty=1, rob_ready=1, rob_idx=0, commit_valid=0, mispredict=0.
- Dispatch 16 entries with no wb → rob_ready=0 after the 16th; a 17th dispatch_valid is ignored and rob_idx stays 0.
- Dispatch idx0..3 (pc 0x100..0x10C), wb order 2,0,3,1 → commits 0x100 when idx0 completes; 0x104,0x108,0x10C commit on consecutive cycles after idx1 completes; P_rd_old values match dispatch.
- Dispatch idx0..4; wb idx1 mispredict target 0x2000, then wb idx0 → idx0 commits, idx1 commits, next cycle mispredict=1 with redirect_pc=0x2000; afterwards rob_empty=1, rob_idx=0, idx2..4 never commit.
- Full ROB with head done; dispatch_valid held → head commits and no dispatch is accepted that cycle; next cycle dispatch is accepted, occupancy stays 16.
- Stream 40 instructions with wb one cycle after dispatch → pointers wrap twice, commit order equals dispatch order, no lost or duplicated commits.
